// File: rtl/mul_add_nat_pkg.sv
// Shared types and helpers for the mul_add_nat multiply-accumulate unit.
package mul_add_nat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of x*y + c for n-bit operands; the maximum 2^2n - 2^n always fits.
  function automatic int result_width(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/mul_add_nat_add.sv
// Parameterised ripple-carry adder: {c_out, s} = x + y + c_in.
module add #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out
);

  logic [N:0] carry;

  // NOTE: every output of a combinational block gets a default first, so no latch can be inferred.
  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = c_in;
    for (int i = 0; i < N; i++) begin
      s[i]         = x[i] ^ y[i] ^ carry[i];
      carry[i+1]   = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end
    c_out = carry[N];
  end

endmodule

// File: rtl/mul_add_nat.sv
// Registered natural multiply-accumulate m = x*y + c with valid/ready handshake.
// Define MUL_ADD_NAT_FAST_EN for the single-cycle array build; default is the iterative shift-add engine.
module mul_add_nat
  import mul_add_nat_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N-1:0]                 x,
  input  logic [N-1:0]                 y,
  input  logic [N-1:0]                 c,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [result_width(N)-1:0]   m
);

  localparam int W = result_width(N);

  state_t         state_q, state_d;
  logic [W-1:0]   m_q;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign m         = m_q;

`ifndef MUL_ADD_NAT_FAST_EN

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  x_q, y_q;
  logic [W-1:0]  acc_q, addend, sum, acc_next;
  logic [CW-1:0] cnt_q;
  logic          sum_carry;
  logic          last;

  assign addend   = W'(x_q) << cnt_q;
  assign last     = (cnt_q == CW'(N - 1));
  assign acc_next = y_q[cnt_q] ? sum : acc_q;

  add #(.N(W)) u_add (
    .x    (acc_q),
    .y    (addend),
    .c_in (1'b0),
    .s    (sum),
    .c_out(sum_carry)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          x_q   <= x;
          y_q   <= y;
          acc_q <= W'(c);
          cnt_q <= '0;
        end
        RUN: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CW'(1);
          if (last) m_q <= acc_next;
        end
        default: ;
      endcase
    end
  end

  // Partial sums are bounded by the final result, so the wide add never carries out.
  always_ff @(posedge clock) begin
    if (!reset && state_q == RUN) assert (!sum_carry);
  end

`else

  logic [W-1:0] fast_m;

  // Row i adds x*y[i] to the upper bits of the previous row; c enters as row 0's addend.
  for (genvar i = 0; i < N; i++) begin : g_row
    logic [N-1:0] row_in, row_s;
    logic         row_c;

    if (i == 0) begin : g_first
      assign row_in = c;
    end else begin : g_next
      assign row_in = {g_row[i-1].row_c, g_row[i-1].row_s[N-1:1]};
    end

    add #(.N(N)) u_add (
      .x    (x & {N{y[i]}}),
      .y    (row_in),
      .c_in (1'b0),
      .s    (row_s),
      .c_out(row_c)
    );

    if (i < N - 1) begin : g_low
      assign fast_m[i] = row_s[0];
    end else begin : g_top
      assign fast_m[W-1:N-1] = {row_c, row_s};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) m_q <= fast_m;
    end
  end

`endif

endmodule

// File: tb/tb_mul_add_nat.sv
// Self-checking bench for mul_add_nat: directed cases, exhaustive N=4 sweep and random backpressure.
// Expectations come from plain integer arithmetic x*y + c and the handshake timing rules.
module tb_mul_add_nat;

  localparam int N = 4;
  localparam int W = 2 * N;
`ifdef MUL_ADD_NAT_FAST_EN
  localparam int LAT = 1;
`else
  localparam int LAT = N + 1;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x, y, c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] m;

  int n_checks = 0;
  int n_errors = 0;

  mul_add_nat #(.N(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .c        (c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .m        (m)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic scramble();
    x = N'($urandom);
    y = N'($urandom);
    c = N'($urandom);
  endtask

  // One full transaction: present operands, wait for the result, hold it for `hold` cycles, release.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] d,
                        input int hold);
    int  exp_m, lat, guard;
    bit  busy_ready, unstable;
    exp_m     = int'(a) * int'(b) + int'(d);
    in_valid  = 1'b1;
    x         = a;
    y         = b;
    c         = d;
    out_ready = 1'b0;
    guard     = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 20) check("accept_timeout", guard, 0);
    @(negedge clock);
    in_valid   = 1'b0;
    lat        = 1;
    busy_ready = 1'b0;
    while (!out_valid && lat < 40) begin
      busy_ready |= in_ready;
      scramble();
      @(negedge clock);
      lat++;
    end
    check("latency", lat, LAT);
    check("result", int'(m), exp_m);
    unstable = 1'b0;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      scramble();
      busy_ready |= in_ready;
      @(negedge clock);
      if (!out_valid || int'(m) != exp_m) unstable = 1'b1;
    end
    if (hold > 0) check("hold_stable", int'(unstable), 0);
    busy_ready |= in_ready;
    check("busy_ready", int'(busy_ready), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("release_valid", int'(out_valid), 0);
    check("release_ready", int'(in_ready), 1);
    check("m_kept", int'(m), exp_m);
  endtask

  initial begin
    int  got_m[$];
    int  got_t[$];
    int  acc_idx;
    bit  pend;
    int  guard;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x = '0; y = '0; c = '0;
    repeat (3) @(negedge clock);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_m", int'(m), 0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", int'(in_ready), 1);

    // Directed cases, including the maximum-value corner.
    run_op(4'd15, 4'd15, 4'd15, 0);
    run_op(4'd0,  4'd0,  4'd0,  0);
    run_op(4'd13, 4'd11, 4'd7,  0);
    run_op(4'd1,  4'd1,  4'd0,  0);
    run_op(4'd9,  4'd6,  4'd3,  10);

    // Reset in the middle of a computation aborts it.
    @(negedge clock);
    in_valid = 1'b1;
    x = 4'd9; y = 4'd9; c = 4'd9;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("mid_reset_in_ready", int'(in_ready), 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_m", int'(m), 0);
    check("abort_in_ready", int'(in_ready), 1);
    run_op(4'd2, 4'd3, 4'd4, 0);

    // Back-to-back with in_valid and out_ready held high.
    @(negedge clock);
    x = 4'd3; y = 4'd5; c = 4'd1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    acc_idx   = 0;
    pend      = in_valid && in_ready;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clock);
      if (out_valid) begin
        got_m.push_back(int'(m));
        got_t.push_back(cyc);
      end
      if (pend) begin
        acc_idx++;
        if (acc_idx == 1) begin
          x = 4'd12; y = 4'd12; c = 4'd0;
        end else begin
          in_valid = 1'b0;
        end
      end
      pend = in_valid && in_ready;
    end
    out_ready = 1'b0;
    check("b2b_count", got_m.size(), 2);
    if (got_m.size() >= 2) begin
      check("b2b_first", got_m[0], 16);
      check("b2b_second", got_m[1], 144);
      check("b2b_spacing", got_t[1] - got_t[0], LAT + 1);
    end

    // Exhaustive sweep of every operand combination.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int d = 0; d < 16; d++)
          run_op(N'(a), N'(b), N'(d), 0);

    // Random operands with random backpressure.
    for (int i = 0; i < 100; i++)
      run_op(N'($urandom), N'($urandom), N'($urandom), int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
